jpeg_byte_stuffer: RTL and testbench



---
 rtl/jpeg_byte_stuffer.sv | 204 ++++++++++++++++++++
 tb/tb_jpeg_byte_stuffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-coded segment byte packer: buffers 32-bit Huffman words, emits MSB-first bytes
// with 0x00 stuffing after every 0xFF, and closes each image with padded residual bits plus EOI (FF D9).
module jpeg_byte_stuffer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] JPEG_bitstream,
    input  logic        data_ready,
    input  logic [4:0]  orc,
    input  logic        flush,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        overflow,
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, EMIT, STUFF, EOI_FF, EOI_D9} state_t;

    typedef struct packed {
        logic        is_flush;
        logic [5:0]  nbits;
        logic [31:0] word;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          wr_en, pop, full, drop, more;
    entry_t        wr_data, head;

    logic          pend_reg, pend_next;
    logic [5:0]    pend_nbits_reg, pend_nbits_next;
    logic [31:0]   pend_word_reg, pend_word_next;
    logic          overflow_reg;

    state_t        state_reg, state_next;
    logic [31:0]   sr_reg, sr_next, pad;
    logic [2:0]    bc_reg, bc_next, load_bc;
    logic          flag_reg, flag_next, hs;

    assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign more     = (count_reg > (AW+1)'(1));
    assign head     = mem[rd_ptr_reg];
    assign pad      = (head.nbits >= 6'd32) ? 32'h0 : (32'hFFFF_FFFF >> head.nbits);
    assign load_bc  = head.nbits[5:3] + {2'b00, |head.nbits[2:0]};
    assign hs       = byte_valid & byte_ready;
    assign overflow = overflow_reg;
    assign busy     = (count_reg != '0) | pend_reg | (state_reg != IDLE);

    // Write arbitration: a pending flush goes first to keep image order; a word
    // arriving in that same cycle has no slot and counts as dropped.
    always_comb begin
        wr_en           = 1'b0;
        wr_data         = '0;
        drop            = 1'b0;
        pend_next       = pend_reg;
        pend_nbits_next = pend_nbits_reg;
        pend_word_next  = pend_word_reg;
        if (pend_reg) begin
            if (!full) begin
                wr_en     = 1'b1;
                wr_data   = {1'b1, pend_nbits_reg, pend_word_reg};
                pend_next = 1'b0;
            end
            drop = data_ready;
        end else if (data_ready) begin
            if (full) begin
                drop = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_data = {1'b0, 6'd32, JPEG_bitstream};
            end
            if (flush) begin
                pend_next       = 1'b1;
                pend_nbits_next = 6'd0;
                pend_word_next  = JPEG_bitstream;
            end
        end else if (flush) begin
            if (full) begin
                pend_next       = 1'b1;
                pend_nbits_next = {1'b0, orc};
                pend_word_next  = JPEG_bitstream;
            end else begin
                wr_en   = 1'b1;
                wr_data = {1'b1, 1'b0, orc, JPEG_bitstream};
            end
        end
    end

    // The head entry stays allocated until its last byte (or EOI) is accepted,
    // so the word being serialized still counts toward FIFO occupancy.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        bc_next    = bc_reg;
        flag_next  = flag_reg;
        pop        = 1'b0;
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) state_next = LOAD;
            end
            LOAD: begin
                sr_next   = head.word | pad;
                bc_next   = load_bc;
                flag_next = head.is_flush;
                if (load_bc != 3'd0) begin
                    state_next = EMIT;
                end else if (head.is_flush) begin
                    state_next = EOI_FF;
                end else begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            EMIT: begin
                byte_out   = sr_reg[31:24];
                byte_valid = 1'b1;
                if (hs) begin
                    sr_next = {sr_reg[23:0], 8'h00};
                    bc_next = bc_reg - 3'd1;
                    if (sr_reg[31:24] == 8'hFF) begin
                        state_next = STUFF;
                    end else if (bc_reg == 3'd1) begin
                        if (flag_reg) begin
                            state_next = EOI_FF;
                        end else begin
                            pop        = 1'b1;
                            state_next = more ? LOAD : IDLE;
                        end
                    end
                end
            end
            STUFF: begin
                byte_valid = 1'b1;
                if (hs) begin
                    if (bc_reg != 3'd0) begin
                        state_next = EMIT;
                    end else if (flag_reg) begin
                        state_next = EOI_FF;
                    end else begin
                        pop        = 1'b1;
                        state_next = more ? LOAD : IDLE;
                    end
                end
            end
            EOI_FF: begin
                byte_out   = 8'hFF;
                byte_valid = 1'b1;
                if (hs) state_next = EOI_D9;
            end
            EOI_D9: begin
                byte_out   = 8'hD9;
                byte_valid = 1'b1;
                byte_last  = 1'b1;
                if (hs) begin
                    pop        = 1'b1;
                    state_next = more ? LOAD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_next = count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            pend_reg       <= 1'b0;
            pend_nbits_reg <= '0;
            pend_word_reg  <= '0;
            overflow_reg   <= 1'b0;
            state_reg      <= IDLE;
            sr_reg         <= '0;
            bc_reg         <= '0;
            flag_reg       <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg      <= count_next;
            pend_reg       <= pend_next;
            pend_nbits_reg <= pend_nbits_next;
            pend_word_reg  <= pend_word_next;
            if (drop) overflow_reg <= 1'b1;
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bc_reg         <= bc_next;
            flag_reg       <= flag_next;
        end
    end
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: each task drives one scenario and checks bytes inline.
module tb_jpeg_byte_stuffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] JPEG_bitstream = '0;
    logic        data_ready = 1'b0;
    logic [4:0]  orc = '0;
    logic        flush = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        byte_last;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_b[$];
    logic       got_l[$];

    jpeg_byte_stuffer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .JPEG_bitstream(JPEG_bitstream), .data_ready(data_ready),
        .orc(orc), .flush(flush), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic dr, input logic fl, input logic [4:0] o);
        JPEG_bitstream = w;
        data_ready     = dr;
        flush          = fl;
        orc            = o;
        cycle();
        data_ready = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int c;
        c = 0;
        got_b.delete();
        got_l.delete();
        while (got_b.size() < n && c < budget) begin
            if (byte_valid && byte_ready) begin
                got_b.push_back(byte_out);
                got_l.push_back(byte_last);
                $display("byte %02h last=%0b", byte_out, byte_last);
            end
            cycle();
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", byte_valid); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte got %02h want 00", byte_out); end
        checks++; if (byte_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", byte_last); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        logic [7:0] exp_b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        byte_ready = 1'b1;
        send(32'h12345678, 1'b1, 1'b0, 5'd0);
        cycle();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL single_latency_n1 valid got %0b want 0", byte_valid); end
        cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== exp_b[i]) begin
                errors++;
                $display("FAIL single_byte%0d got valid=%0b %02h want valid=1 %02h", i, byte_valid, byte_out, exp_b[i]);
            end else begin
                $display("byte %02h", byte_out);
            end
            cycle();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", busy); end
    endtask

    task automatic test_stuffing();
        logic [7:0] exp_b[6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
        byte_ready = 1'b1;
        send(32'hFF00FFAB, 1'b1, 1'b0, 5'd0);
        collect(6, 40);
        checks++; if (got_b.size() != 6) begin errors++; $display("FAIL stuff_count got %0d want 6", got_b.size()); end
        for (int i = 0; i < 6 && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_l[i] !== 1'b0) begin
                errors++;
                $display("FAIL stuff_byte%0d got %02h last=%0b want %02h last=0", i, got_b[i], got_l[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_b[5] = '{8'hA5, 8'hFF, 8'h00, 8'hFF, 8'hD9};
        byte_ready = 1'b1;
        send(32'hA5C00000, 1'b0, 1'b1, 5'd10);
        collect(5, 40);
        checks++; if (got_b.size() != 5) begin errors++; $display("FAIL flush_count got %0d want 5", got_b.size()); end
        for (int i = 0; i < 5 && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL flush_byte%0d got %02h last=%0b want %02h last=%0b", i, got_b[i], got_l[i], exp_b[i], (i == 4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[3] = '{8'hAB, 8'hCD, 8'hEF};
        int c;
        byte_ready = 1'b1;
        send(32'h89ABCDEF, 1'b1, 1'b0, 5'd0);
        c = 0;
        while (!byte_valid && c < 10) begin cycle(); c++; end
        checks++; if (byte_valid !== 1'b1 || byte_out !== 8'h89) begin errors++; $display("FAIL bp_first got valid=%0b %02h want valid=1 89", byte_valid, byte_out); end
        cycle();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== 8'hAB) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%0b %02h want valid=1 AB", i, byte_valid, byte_out);
            end
            cycle();
        end
        byte_ready = 1'b1;
        collect(3, 20);
        checks++; if (got_b.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_b.size()); end
        for (int i = 0; i < 3 && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %02h want %02h", i, got_b[i], exp_b[i]); end
        end
        cycle();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL bp_extra got valid=%0b want 0", byte_valid); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hD9};
        byte_ready = 1'b1;
        send(32'h11223344, 1'b1, 1'b1, 5'd20);
        collect(6, 40);
        checks++; if (got_b.size() != 6) begin errors++; $display("FAIL simul_count got %0d want 6", got_b.size()); end
        for (int i = 0; i < 6 && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_l[i] !== (i == 5)) begin
                errors++;
                $display("FAIL simul_byte%0d got %02h last=%0b want %02h last=%0b", i, got_b[i], got_l[i], exp_b[i], (i == 5));
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        byte_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(32'(k), 1'b1, 1'b0, 5'd0);
            if (k == 4) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
        byte_ready = 1'b1;
        collect(16, 100);
        checks++; if (got_b.size() != 16) begin errors++; $display("FAIL ovf_count got %0d want 16", got_b.size()); end
        for (int i = 0; i < 16 && i < got_b.size(); i++) begin
            want = (i % 4 == 3) ? 8'(i / 4 + 1) : 8'h00;
            checks++;
            if (got_b[i] !== want) begin errors++; $display("FAIL ovf_byte%0d got %02h want %02h", i, got_b[i], want); end
        end
        cycle();
        cycle();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL ovf_word5 got valid=%0b want 0", byte_valid); end
    endtask

    task automatic test_reset_mid();
        int c;
        int seen;
        byte_ready = 1'b1;
        send(32'hCAFEBABE, 1'b1, 1'b0, 5'd0);
        c = 0;
        while (!byte_valid && c < 10) begin cycle(); c++; end
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL rstmid_start got valid=%0b want 1", byte_valid); end
        cycle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rstmid_sticky got %0b want 1", overflow); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", byte_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %0b want 0", overflow); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (byte_valid) seen++;
            cycle();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_quiet got %0d bytes want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stuffing();
        test_flush();
        test_backpressure();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
